con_seq: RTL and testbench
==========================

CON_SEQ -- requirements
Module: con_seq

Interface
REQ-001 The block SHALL have parameter IW, default 8, meaning instruction width; the opcode is ir[IW-1:IW-4], legal only when IW >= 4+2*RAW.
REQ-002 The block SHALL have parameter RAW, default 2, meaning register-address width; wa = ir[2*RAW-1:RAW], ra = ir[RAW-1:0].
REQ-003 The block SHALL have parameter CW, default 16, meaning retired-instruction counter width.
REQ-004 Ports SHALL be exactly the following; one clock; reset is asynchronous and active-low.
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  ir  in  IW  current instruction word
  alu_c, alu_z  in  1 each  ALU carry/zero for the current EXEC cycle
  step  in  1  single-step release (CON_STEP_EN only)
  alu_s  out  4  equals opcode
  alu_m, shi_fbus, shi_flbus, shi_frbus  out  1 each  ALU mode, shifter pass/left/right onto bus
  madd  out  2  address select: 00 PC, 01 register (read), 10 register (write)
  reg_ra, reg_wa  out  RAW each  register read/write addresses
  reg_we_n, ram_rd_n, ram_wr_n  out  1 each  active-low register write, RAM read, RAM write
  pc_ld, pc_inc, ir_ld, in_en, out_en  out  1 each  PC load/increment, IR load, input/output enable
  c_flag, z_flag  out  1 each  latched flags
  halted  out  1  high in HALT state
  instr_cnt  out  CW  retired-instruction count

Function
REQ-005 Opcodes: 0 NOP, 1 MOVA, 2 MOVB, 3 MOVC, 4 ADD, 5 SUB, 6 AND, 7 NOT, 8 RSR, 9 RSL, A JMP, B JZ, C JC, D IN, E OUT, F HALT.
REQ-006 States: IDLE, FETCH, EXEC, PAUSE, HALT; all outputs SHALL be combinational from state, opcode and flags only.
REQ-007 IDLE: all controls inactive; the next state is FETCH.
REQ-008 FETCH: ir_ld=1, ram_rd_n=0, madd=00, pc_inc=1; the next state is EXEC.
REQ-009 EXEC: madd=01 for MOVC and 10 for MOVB, else 00.
REQ-010 EXEC: ram_rd_n=0 for MOVC, JMP, JZ, JC.
REQ-011 EXEC: ram_wr_n=0 for MOVB only.
REQ-012 EXEC: reg_we_n=0 for MOVA, MOVC, ADD, SUB, AND, NOT, RSR, RSL, IN.
REQ-013 EXEC: shi_fbus=1 for MOVA, MOVB, ADD, SUB, AND, NOT, OUT; shi_flbus=1 for RSL; shi_frbus=1 for RSR.
REQ-014 EXEC: alu_m=1 for ADD, SUB, AND, NOT, RSR, RSL, OUT; in_en=1 for IN; out_en=1 for OUT.
REQ-015 Jumps (two-word, operand at PC) SHALL be taken when JMP, JZ with z_flag=1, or JC with c_flag=1; taken gives pc_ld=1, not taken gives pc_inc=1 (operand skipped).
REQ-016 Jump conditions SHALL use flag values latched before the current EXEC.
REQ-017 At the EXEC clock edge, c_flag SHALL load alu_c for ADD, SUB, RSR, RSL, and z_flag SHALL load alu_z for ADD, SUB; otherwise both flags hold.
REQ-018 EXEC SHALL last exactly one cycle; the next state is HALT for opcode F, PAUSE per REQ-023, else FETCH.
REQ-019 instr_cnt SHALL increment at every EXEC exit, HALT included, and wrap from 2^CW-1 to 0.
REQ-020 HALT: halted=1, all controls inactive, flags and instr_cnt frozen; exit is by reset only.
REQ-021 reg_ra and reg_wa SHALL always reflect ir fields; alu_s SHALL always equal the opcode.

Reset
REQ-022 When rst_n=0, the block SHALL asynchronously go to IDLE with c_flag=0, z_flag=0, instr_cnt=0; all active-high outputs read 0 and active-low outputs read 1, regardless of current state, including mid-EXEC.

Configuration
REQ-023 With CON_STEP_EN defined, non-HALT EXEC SHALL go to PAUSE (all controls inactive); PAUSE SHALL move to FETCH on a cycle sampling step=1 and hold otherwise; step=1 in other states SHALL be ignored.
REQ-024 Without CON_STEP_EN, the step port SHALL exist but be ignored, and PAUSE SHALL be unreachable.

Verification
REQ-025 Reset then ir=8'h40 (ADD) with alu_c=1, alu_z=0: cycle 1 IDLE; cycle 2 FETCH with ir_ld=1, pc_inc=1; cycle 3 EXEC with reg_we_n=0, alu_m=1; after the edge c_flag=1, z_flag=0, instr_cnt=1.
REQ-026 z_flag=0 with ir=8'hB0 (JZ): pc_ld=0, pc_inc=1, ram_rd_n=0 in EXEC; with z_flag=1: pc_ld=1, pc_inc=0.
REQ-027 ir=8'h26 (MOVB, wa=01, ra=10): EXEC gives madd=10, ram_wr_n=0, shi_fbus=1, reg_we_n=1.
REQ-028 ir=8'hF0: halted=1 from the cycle after EXEC; 20 further cycles leave instr_cnt and all controls unchanged; rst_n low mid-HALT returns the block to IDLE immediately.
REQ-029 CW=2 running NOPs: instr_cnt counts 1, 2, 3, 0.
REQ-030 With CON_STEP_EN, NOP: the block stays in PAUSE for 5 cycles with step=0, then enters FETCH exactly one cycle after step=1 is sampled.

Source files
------------

// File: rtl/con_seq.sv
// con_seq: instruction control sequencer (IDLE -> FETCH -> EXEC loop, HALT until reset).
// Define CON_STEP_EN to add a PAUSE state after every non-HALT EXEC, released by step.
module con_seq #(
  parameter int unsigned IW  = 8,
  parameter int unsigned RAW = 2,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  ir,
  input  logic           alu_c,
  input  logic           alu_z,
  input  logic           step,
  output logic [3:0]     alu_s,
  output logic           alu_m,
  output logic           shi_fbus,
  output logic           shi_flbus,
  output logic           shi_frbus,
  output logic [1:0]     madd,
  output logic [RAW-1:0] reg_ra,
  output logic [RAW-1:0] reg_wa,
  output logic           reg_we_n,
  output logic           ram_rd_n,
  output logic           ram_wr_n,
  output logic           pc_ld,
  output logic           pc_inc,
  output logic           ir_ld,
  output logic           in_en,
  output logic           out_en,
  output logic           c_flag,
  output logic           z_flag,
  output logic           halted,
  output logic [CW-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_MOVB = 4'h2;
  localparam logic [3:0] OP_MOVC = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_RSR  = 4'h8;
  localparam logic [3:0] OP_RSL  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

`ifdef CON_STEP_EN
  localparam state_t S_POST_EXEC = S_PAUSE;
`else
  localparam state_t S_POST_EXEC = S_FETCH;
  logic unused_step;
  assign unused_step = step;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op;
  logic       take_jump;

  assign op     = ir[IW-1 -: 4];
  assign alu_s  = op;
  assign reg_wa = ir[2*RAW-1:RAW];
  assign reg_ra = ir[RAW-1:0];
  assign halted = (state == S_HALT);

  // Jump decision uses the flags as they stood before this EXEC edge
  assign take_jump = (op == OP_JMP) || ((op == OP_JZ) && z_flag) || ((op == OP_JC) && c_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_m     = 1'b0;
    shi_fbus  = 1'b0;
    shi_flbus = 1'b0;
    shi_frbus = 1'b0;
    madd      = 2'b00;
    reg_we_n  = 1'b1;
    ram_rd_n  = 1'b1;
    ram_wr_n  = 1'b1;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    ir_ld     = 1'b0;
    in_en     = 1'b0;
    out_en    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        ir_ld     = 1'b1;
        ram_rd_n  = 1'b0;
        pc_inc    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = (op == OP_HALT) ? S_HALT : S_POST_EXEC;
        case (op)
          OP_MOVA: begin
            reg_we_n = 1'b0;
            shi_fbus = 1'b1;
          end
          OP_MOVB: begin
            madd     = 2'b10;
            ram_wr_n = 1'b0;
            shi_fbus = 1'b1;
          end
          OP_MOVC: begin
            madd     = 2'b01;
            ram_rd_n = 1'b0;
            reg_we_n = 1'b0;
          end
          OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
            reg_we_n = 1'b0;
            shi_fbus = 1'b1;
            alu_m    = 1'b1;
          end
          OP_RSR: begin
            reg_we_n  = 1'b0;
            shi_frbus = 1'b1;
            alu_m     = 1'b1;
          end
          OP_RSL: begin
            reg_we_n  = 1'b0;
            shi_flbus = 1'b1;
            alu_m     = 1'b1;
          end
          // Two-word jumps: operand sits at PC, so a not-taken jump skips it
          OP_JMP, OP_JZ, OP_JC: begin
            ram_rd_n = 1'b0;
            pc_ld    = take_jump;
            pc_inc   = !take_jump;
          end
          OP_IN: begin
            reg_we_n = 1'b0;
            in_en    = 1'b1;
          end
          OP_OUT: begin
            shi_fbus = 1'b1;
            alu_m    = 1'b1;
            out_en   = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: ;
        endcase
      end
`ifdef CON_STEP_EN
      S_PAUSE: if (step) state_nxt = S_FETCH;
`else
      S_PAUSE: state_nxt = S_FETCH;
`endif
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flags and retired count update on the EXEC edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      instr_cnt <= '0;
    end else if (state == S_EXEC) begin
      instr_cnt <= instr_cnt + CW'(1);
      case (op)
        OP_ADD, OP_SUB: begin
          c_flag <= alu_c;
          z_flag <= alu_z;
        end
        OP_RSR, OP_RSL: c_flag <= alu_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_con_seq.sv
// Self-checking bench for con_seq: opcode-table model compared every cycle plus directed literal checks.
module tb_con_seq;
  localparam int unsigned IW  = 8;
  localparam int unsigned RAW = 2;
  localparam int unsigned CW  = 16;

`ifdef CON_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // Opcode sets, bit n = opcode n
  localparam logic [15:0] MASK_WE   = 16'h23FA;
  localparam logic [15:0] MASK_FBUS = 16'h40F6;
  localparam logic [15:0] MASK_ALUM = 16'h43F0;
  localparam logic [15:0] MASK_CUPD = 16'h0330;
  localparam logic [15:0] MASK_ZUPD = 16'h0030;
  localparam logic [15:0] MASK_RD   = 16'h1C08;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] ir = '0;
  logic          alu_c = 1'b0;
  logic          alu_z = 1'b0;
  logic          step = 1'b0;

  logic [3:0]     alu_s;
  logic           alu_m, shi_fbus, shi_flbus, shi_frbus;
  logic [1:0]     madd;
  logic [RAW-1:0] reg_ra, reg_wa;
  logic           reg_we_n, ram_rd_n, ram_wr_n;
  logic           pc_ld, pc_inc, ir_ld, in_en, out_en;
  logic           c_flag, z_flag, halted;
  logic [CW-1:0]  instr_cnt;

  logic [3:0]     d2_alu_s;
  logic           d2_alu_m, d2_shi_fbus, d2_shi_flbus, d2_shi_frbus;
  logic [1:0]     d2_madd;
  logic [RAW-1:0] d2_reg_ra, d2_reg_wa;
  logic           d2_reg_we_n, d2_ram_rd_n, d2_ram_wr_n;
  logic           d2_pc_ld, d2_pc_inc, d2_ir_ld, d2_in_en, d2_out_en;
  logic           d2_c_flag, d2_z_flag, d2_halted;
  logic [1:0]     d2_instr_cnt;

  con_seq #(.IW(IW), .RAW(RAW), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .alu_c(alu_c), .alu_z(alu_z), .step(step),
    .alu_s(alu_s), .alu_m(alu_m), .shi_fbus(shi_fbus), .shi_flbus(shi_flbus),
    .shi_frbus(shi_frbus), .madd(madd), .reg_ra(reg_ra), .reg_wa(reg_wa),
    .reg_we_n(reg_we_n), .ram_rd_n(ram_rd_n), .ram_wr_n(ram_wr_n), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .ir_ld(ir_ld), .in_en(in_en), .out_en(out_en), .c_flag(c_flag),
    .z_flag(z_flag), .halted(halted), .instr_cnt(instr_cnt)
  );

  con_seq #(.IW(IW), .RAW(RAW), .CW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ir(ir), .alu_c(alu_c), .alu_z(alu_z), .step(step),
    .alu_s(d2_alu_s), .alu_m(d2_alu_m), .shi_fbus(d2_shi_fbus), .shi_flbus(d2_shi_flbus),
    .shi_frbus(d2_shi_frbus), .madd(d2_madd), .reg_ra(d2_reg_ra), .reg_wa(d2_reg_wa),
    .reg_we_n(d2_reg_we_n), .ram_rd_n(d2_ram_rd_n), .ram_wr_n(d2_ram_wr_n), .pc_ld(d2_pc_ld),
    .pc_inc(d2_pc_inc), .ir_ld(d2_ir_ld), .in_en(d2_in_en), .out_en(d2_out_en),
    .c_flag(d2_c_flag), .z_flag(d2_z_flag), .halted(d2_halted), .instr_cnt(d2_instr_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 fetch, 2 exec, 3 pause, 4 halt
  int            m_phase = 0;
  logic          m_c = 1'b0;
  logic          m_z = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [3:0]    cur_op;
  assign cur_op = ir[IW-1 -: 4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_c     <= 1'b0;
      m_z     <= 1'b0;
      m_cnt   <= '0;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: m_phase <= 2;
        2: begin
          m_cnt <= m_cnt + CW'(1);
          if (MASK_CUPD[cur_op]) m_c <= alu_c;
          if (MASK_ZUPD[cur_op]) m_z <= alu_z;
          if (cur_op == 4'hF) m_phase <= 4;
          else                m_phase <= STEP_EN ? 3 : 1;
        end
        3: if (step) m_phase <= 1;
        default: ;
      endcase
    end
  end

  function automatic logic [63:0] model_vec();
    logic [3:0] op;
    logic am, fb, fl, fr, we_n, rd_n, wr_n, pld, pinc, irl, ien, oen, hlt, take;
    logic [1:0] md;
    op = ir[IW-1 -: 4];
    am = 1'b0; fb = 1'b0; fl = 1'b0; fr = 1'b0; md = 2'b00;
    we_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    pld = 1'b0; pinc = 1'b0; irl = 1'b0; ien = 1'b0; oen = 1'b0;
    hlt = (m_phase == 4);
    if (m_phase == 1) begin
      irl = 1'b1; rd_n = 1'b0; pinc = 1'b1;
    end else if (m_phase == 2) begin
      am   = MASK_ALUM[op];
      fb   = MASK_FBUS[op];
      fl   = (op == 4'h9);
      fr   = (op == 4'h8);
      we_n = !MASK_WE[op];
      rd_n = !MASK_RD[op];
      wr_n = (op != 4'h2);
      md   = (op == 4'h3) ? 2'b01 : (op == 4'h2) ? 2'b10 : 2'b00;
      ien  = (op == 4'hD);
      oen  = (op == 4'hE);
      if (op >= 4'hA && op <= 4'hC) begin
        take = (op == 4'hA) || (op == 4'hB && m_z) || (op == 4'hC && m_c);
        pld  = take;
        pinc = !take;
      end
    end
    return {23'b0, op, ir[2*RAW-1:RAW], ir[RAW-1:0], am, fb, fl, fr, md, we_n, rd_n, wr_n,
            pld, pinc, irl, ien, oen, hlt, m_c, m_z, m_cnt};
  endfunction

  logic [63:0] got_vec;
  assign got_vec = {23'b0, alu_s, reg_wa, reg_ra, alu_m, shi_fbus, shi_flbus, shi_frbus, madd,
                    reg_we_n, ram_rd_n, ram_wr_n, pc_ld, pc_inc, ir_ld, in_en, out_en, halted,
                    c_flag, z_flag, instr_cnt};

  always @(negedge clk) if (chk_en) check("cycle", got_vec, model_vec());

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to a FETCH cycle, present the word, then step into its EXEC cycle
  task automatic exec_instr(input logic [IW-1:0] w);
    int n = 0;
    while (!ir_ld && n < 8) begin
      tick();
      n++;
    end
    check("reach_fetch", 64'(ir_ld), 64'd1);
    ir = w;
    tick();
  endtask

  logic [63:0] hold_vec;

  initial begin
    rst_n = 1'b0; ir = 8'h40; alu_c = 1'b1; alu_z = 1'b0; step = 1'b1;
    tick(); tick();
    check("rst_cnt", 64'(instr_cnt), 64'd0);
    check("rst_flags", 64'({c_flag, z_flag}), 64'd0);
    check("rst_ctl_n", 64'({reg_we_n, ram_rd_n, ram_wr_n}), 64'b111);
    check("rst_ctl", 64'({ir_ld, pc_inc, pc_ld, halted, alu_m}), 64'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    check("c1_idle", 64'({ir_ld, pc_inc}), 64'd0);
    tick(); check("c2_fetch", 64'({ir_ld, pc_inc}), 64'b11);
    tick(); check("c3_exec", 64'({reg_we_n, alu_m}), 64'b01);
    tick(); check("add_flags", 64'({c_flag, z_flag}), 64'b10);
    check("add_cnt", 64'(instr_cnt), 64'd1);

    exec_instr(8'hB0); check("jz_not_taken", 64'({pc_ld, pc_inc, ram_rd_n}), 64'b010);
    alu_z = 1'b1; exec_instr(8'h40);
    exec_instr(8'hB0); check("jz_taken", 64'({pc_ld, pc_inc}), 64'b10);
    alu_c = 1'b0; alu_z = 1'b0; exec_instr(8'h40);
    check("flag_old_in_exec", 64'(c_flag), 64'd1);
    tick(); check("flag_new", 64'({c_flag, z_flag}), 64'd0);
    exec_instr(8'hC0); check("jc_not_taken", 64'({pc_ld, pc_inc}), 64'b01);
    exec_instr(8'h26);
    check("movb", 64'({madd, ram_wr_n, shi_fbus, reg_we_n, reg_wa, reg_ra}),
          64'({2'b10, 1'b0, 1'b1, 1'b1, 2'b01, 2'b10}));

    for (int op = 0; op < 15; op++) begin
      alu_c = op[0];
      alu_z = op[1];
      exec_instr({4'(op), 4'(op * 5)});
    end

    exec_instr(8'h40); check("pre_rst_we", 64'(reg_we_n), 64'd0);
    rst_n = 1'b0; #1;
    check("async_rst_exec", 64'({reg_we_n, alu_m, instr_cnt, c_flag, z_flag}),
          64'({1'b1, 1'b0, 16'd0, 2'b00}));
    tick(); rst_n = 1'b1;

    exec_instr(8'hF0);
    tick(); check("halted", 64'({halted, ir_ld}), 64'b10);
    hold_vec = got_vec;
    for (int i = 0; i < 20; i++) begin
      alu_c = i[0]; alu_z = i[1]; step = i[2];
      tick();
    end
    check("halt_freeze", got_vec, hold_vec);
    check("halt_cnt", 64'(instr_cnt), 64'd1);
    rst_n = 1'b0; #1;
    check("halt_rst", 64'({halted, instr_cnt}), 64'd0);
    tick(); rst_n = 1'b1; step = 1'b1; ir = 8'h00;

    for (int k = 1; k <= 4; k++) begin
      exec_instr(8'h00);
      tick();
      check("cw2_cnt", 64'(d2_instr_cnt), 64'(k % 4));
    end

`ifdef CON_STEP_EN
    exec_instr(8'h00);
    step = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("pause_hold", 64'({ir_ld, reg_we_n}), 64'b01);
      tick();
    end
    step = 1'b1;
    check("pause_pre_step", 64'(ir_ld), 64'd0);
    tick(); check("step_fetch", 64'(ir_ld), 64'd1);
`endif

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
